bram_fifo_sync: RTL and testbench

BRAM_FIFO_SYNC -- requirements
Module: bram_fifo_sync

---
 rtl/bram_fifo_sync.sv | 162 ++++++++++++++++
 tb/tb_bram_fifo_sync.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_fifo_sync.sv
// bram_fifo_sync: single-clock FIFO built on a simple-dual-port RAM that can be
// inferred as block RAM. It has a standard read mode and a first-word-fall-through
// mode, plus registered status flags and single-cycle error pulses.
// Ports:
//   clk, reset          - clock and asynchronous active-high reset
//   wr_en, wr_data      - write request and the word to write
//   rd_en               - read request (a pop in FWFT mode)
//   rd_data, rd_valid   - read word and its valid strobe (in FWFT mode, rd_valid = not empty)
//   full, afull         - FIFO full / almost full (level >= AFULL_LVL)
//   empty, aempty       - FIFO empty / almost empty (level <= AEMPTY_LVL)
//   level               - number of words held, including words in the FWFT pipeline
//   overflow, underflow - one-cycle pulses when a write or read request is rejected
module bram_fifo_sync #(
  parameter int unsigned DATA       = 8,
  parameter int unsigned ADDR       = 12,
  parameter int unsigned FWFT       = 0,
  parameter int unsigned AFULL_LVL  = (1 << ADDR) - 4,
  parameter int unsigned AEMPTY_LVL = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [DATA-1:0] wr_data,
  input  logic            rd_en,
  output logic [DATA-1:0] rd_data,
  output logic            rd_valid,
  output logic            full,
  output logic            afull,
  output logic            empty,
  output logic            aempty,
  output logic [ADDR:0]   level,
  output logic            overflow,
  output logic            underflow
);

  localparam int unsigned LW        = ADDR + 1;
  localparam int unsigned DEPTH     = 1 << ADDR;
  localparam bit          FWFT_MODE = (FWFT != 0);

  logic [DATA-1:0] r_mem [DEPTH];

  logic [ADDR-1:0] r_wr_ptr;
  logic [ADDR-1:0] r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic [LW-1:0]   r_mem_cnt;   // FWFT: words in the RAM that have not been fetched yet
  logic [DATA-1:0] r_ram_q;     // FWFT: registered RAM read data (prefetch stage)
  logic            r_ram_vld;
  logic            r_out_vld;   // FWFT: the output register holds the head word
  logic [DATA-1:0] r_rd_data;
  logic            r_rd_valid;
  logic            r_full;
  logic            r_afull;
  logic            r_empty;
  logic            r_aempty;
  logic            r_overflow;
  logic            r_underflow;

  logic            w_wr_acc;
  logic            w_rd_acc;
  logic            w_fetch;
  logic            w_out_load;
  logic            w_rd_adv;
  logic            w_ram_vld_nxt;
  logic            w_out_vld_nxt;
  logic            w_empty_nxt;
  logic            w_rd_valid_nxt;
  logic [LW-1:0]   w_level_nxt;
  logic [LW-1:0]   w_mem_cnt_nxt;

  // Accept/advance decisions and next-state values for the counters and flags
  always_comb begin
    w_wr_acc       = wr_en & ~r_full;
    w_rd_acc       = 1'b0;
    w_fetch        = 1'b0;
    w_out_load     = 1'b0;
    w_rd_adv       = 1'b0;
    w_out_vld_nxt  = 1'b0;
    w_mem_cnt_nxt  = '0;
    w_empty_nxt    = 1'b1;
    w_rd_valid_nxt = 1'b0;
    w_level_nxt    = r_level;

    if (FWFT_MODE) begin
      // A pop frees the output register, which refills from the prefetch stage.
      // The prefetch stage refills from the RAM in the same cycle.
      w_rd_acc       = rd_en & r_out_vld;
      w_out_load     = r_ram_vld & (~r_out_vld | w_rd_acc);
      w_fetch        = (r_mem_cnt != '0) & (~r_ram_vld | w_out_load);
      w_rd_adv       = w_fetch;
      w_out_vld_nxt  = w_out_load | (r_out_vld & ~w_rd_acc);
      w_mem_cnt_nxt  = r_mem_cnt + LW'(w_wr_acc) - LW'(w_fetch);
      w_level_nxt    = r_level + LW'(w_wr_acc) - LW'(w_rd_acc);
      w_empty_nxt    = ~w_out_vld_nxt;
      w_rd_valid_nxt = w_out_vld_nxt;
    end else begin
      w_rd_acc       = rd_en & ~r_empty;
      w_rd_adv       = w_rd_acc;
      w_level_nxt    = r_level + LW'(w_wr_acc) - LW'(w_rd_acc);
      w_empty_nxt    = (w_level_nxt == '0);
      w_rd_valid_nxt = w_rd_acc;
    end

    w_ram_vld_nxt = w_fetch | (r_ram_vld & ~w_out_load);
  end

  // RAM write port and registered read; the array has no reset so it can map to block RAM
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= wr_data;
    if (w_fetch)  r_ram_q         <= r_mem[r_rd_ptr];
  end

  // Pointers, counters, output data and registered flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_mem_cnt   <= '0;
      r_ram_vld   <= 1'b0;
      r_out_vld   <= 1'b0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_full      <= 1'b0;
      r_afull     <= 1'b0;
      r_empty     <= 1'b1;
      r_aempty    <= 1'b1;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + ADDR'(1);
      if (w_rd_adv) r_rd_ptr <= r_rd_ptr + ADDR'(1);
      r_level     <= w_level_nxt;
      r_mem_cnt   <= w_mem_cnt_nxt;
      r_ram_vld   <= w_ram_vld_nxt;
      r_out_vld   <= w_out_vld_nxt;
      if (FWFT_MODE) begin
        if (w_out_load) r_rd_data <= r_ram_q;
      end else begin
        if (w_rd_acc)   r_rd_data <= r_mem[r_rd_ptr];
      end
      r_rd_valid  <= w_rd_valid_nxt;
      r_full      <= (w_level_nxt == LW'(DEPTH));
      r_afull     <= (w_level_nxt >= LW'(AFULL_LVL));
      r_empty     <= w_empty_nxt;
      r_aempty    <= (w_level_nxt <= LW'(AEMPTY_LVL));
      // Rejections are judged against the current flags, whatever the other port does
      r_overflow  <= wr_en & r_full;
      r_underflow <= rd_en & r_empty;
    end
  end

  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign full      = r_full;
  assign afull     = r_afull;
  assign empty     = r_empty;
  assign aempty    = r_aempty;
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_bram_fifo_sync.sv
// Directed bench for bram_fifo_sync with one standard-mode instance and one FWFT-mode instance.
module tb_bram_fifo_sync;

  logic       clk;
  logic       reset;

  logic       s_wr, s_rd;
  logic [7:0] s_wd, s_rdata;
  logic       s_rvld, s_full, s_afull, s_empty, s_aempty, s_ovf, s_unf;
  logic [4:0] s_level;

  logic       f_wr, f_rd;
  logic [7:0] f_wd, f_rdata;
  logic       f_rvld, f_full, f_afull, f_empty, f_aempty, f_ovf, f_unf;
  logic [4:0] f_level;

  int n_tests = 0;
  int n_fail  = 0;

  bram_fifo_sync #(.DATA(8), .ADDR(4), .FWFT(0), .AFULL_LVL(12), .AEMPTY_LVL(4)) u_std (
    .clk(clk), .reset(reset), .wr_en(s_wr), .wr_data(s_wd), .rd_en(s_rd),
    .rd_data(s_rdata), .rd_valid(s_rvld), .full(s_full), .afull(s_afull),
    .empty(s_empty), .aempty(s_aempty), .level(s_level),
    .overflow(s_ovf), .underflow(s_unf)
  );

  bram_fifo_sync #(.DATA(8), .ADDR(4), .FWFT(1), .AFULL_LVL(12), .AEMPTY_LVL(4)) u_fwft (
    .clk(clk), .reset(reset), .wr_en(f_wr), .wr_data(f_wd), .rd_en(f_rd),
    .rd_data(f_rdata), .rd_valid(f_rvld), .full(f_full), .afull(f_afull),
    .empty(f_empty), .aempty(f_aempty), .level(f_level),
    .overflow(f_ovf), .underflow(f_unf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_std_reset(input string tag);
    check({tag, " level"},    32'(s_level), 0);
    check({tag, " empty"},    32'(s_empty), 1);
    check({tag, " aempty"},   32'(s_aempty), 1);
    check({tag, " full"},     32'(s_full), 0);
    check({tag, " afull"},    32'(s_afull), 0);
    check({tag, " rd_valid"}, 32'(s_rvld), 0);
    check({tag, " rd_data"},  32'(s_rdata), 0);
    check({tag, " overflow"}, 32'(s_ovf), 0);
    check({tag, " underflow"},32'(s_unf), 0);
  endtask

  logic [7:0] v3 [3];

  initial begin
    v3 = '{8'h11, 8'h22, 8'h33};
    reset = 1'b1;
    s_wr = 1'b0; s_rd = 1'b0; s_wd = '0;
    f_wr = 1'b0; f_rd = 1'b0; f_wd = '0;
    #2;
    check_std_reset("rst");
    check("rst fwft empty", 32'(f_empty), 1);
    check("rst fwft rd_valid", 32'(f_rvld), 0);
    step();
    step();
    reset = 1'b0;

    // Three writes then three reads
    s_wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_wd = v3[i];
      step();
    end
    s_wr = 1'b0;
    check("w3 level", 32'(s_level), 3);
    s_rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("r3 data", 32'(s_rdata), 32'(v3[i]));
      check("r3 valid", 32'(s_rvld), 1);
      check("r3 level", 32'(s_level), 32'(2 - i));
    end
    s_rd = 1'b0;
    check("r3 empty", 32'(s_empty), 1);
    step();
    check("idle valid", 32'(s_rvld), 0);
    check("idle hold", 32'(s_rdata), 32'h33);

    // Fill to full with flag thresholds, then one overflowing write
    s_wr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_wd = 8'h80 + 8'(i);
      step();
      if (i == 3)  check("aempty at 4", 32'(s_aempty), 1);
      if (i == 4)  check("aempty at 5", 32'(s_aempty), 0);
      if (i == 10) check("afull at 11", 32'(s_afull), 0);
      if (i == 11) check("afull at 12", 32'(s_afull), 1);
    end
    check("fill full", 32'(s_full), 1);
    check("fill level", 32'(s_level), 16);
    s_wd = 8'hEE;
    step();
    check("ovf pulse", 32'(s_ovf), 1);
    check("ovf level", 32'(s_level), 16);
    s_wr = 1'b0;
    step();
    check("ovf clear", 32'(s_ovf), 0);
    s_rd = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      check("drain data", 32'(s_rdata), 32'h80 + 32'(i));
      check("drain valid", 32'(s_rvld), 1);
    end
    s_rd = 1'b0;
    check("drain empty", 32'(s_empty), 1);
    check("drain level", 32'(s_level), 0);

    // Read while empty with a simultaneous write
    s_rd = 1'b1; s_wr = 1'b1; s_wd = 8'h5A;
    step();
    check("unf pulse", 32'(s_unf), 1);
    check("unf level", 32'(s_level), 1);
    check("unf valid", 32'(s_rvld), 0);
    s_rd = 1'b0; s_wr = 1'b0;
    step();
    check("unf clear", 32'(s_unf), 0);
    s_rd = 1'b1;
    step();
    s_rd = 1'b0;
    check("unf data", 32'(s_rdata), 32'h5A);

    // Fill to 8, then 40 cycles of simultaneous read and write across the wrap
    s_wr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_wd = 8'(i);
      step();
    end
    check("stream level0", 32'(s_level), 8);
    s_rd = 1'b1;
    for (int j = 0; j < 40; j++) begin
      s_wd = 8'(8 + j);
      step();
      check("stream data", 32'(s_rdata), 32'(j));
      check("stream level", 32'(s_level), 8);
      check("stream ovf", 32'(s_ovf), 0);
      check("stream unf", 32'(s_unf), 0);
    end
    s_rd = 1'b0;
    s_wd = 8'h99;
    step();
    s_wr = 1'b0;
    check("pre-rst level", 32'(s_level), 9);

    // Asynchronous reset between edges, then reuse
    #3 reset = 1'b1;
    #1;
    check_std_reset("midrst");
    #2 reset = 1'b0;
    s_wr = 1'b1; s_wd = 8'h77;
    step();
    s_wr = 1'b0;
    check("post-rst level", 32'(s_level), 1);
    s_rd = 1'b1;
    step();
    s_rd = 1'b0;
    check("post-rst data", 32'(s_rdata), 32'h77);
    check("post-rst empty", 32'(s_empty), 1);

    // FWFT: single word latency and pop
    f_wr = 1'b1; f_wd = 8'hA5;
    step();
    f_wr = 1'b0;
    check("fwft N empty", 32'(f_empty), 1);
    check("fwft N level", 32'(f_level), 1);
    step();
    step();
    check("fwft N+2 data", 32'(f_rdata), 32'hA5);
    check("fwft N+2 empty", 32'(f_empty), 0);
    check("fwft N+2 valid", 32'(f_rvld), 1);
    f_rd = 1'b1;
    step();
    f_rd = 1'b0;
    check("fwft pop empty", 32'(f_empty), 1);
    check("fwft pop level", 32'(f_level), 0);
    check("fwft pop valid", 32'(f_rvld), 0);

    // FWFT: underflow, then three words popped back-to-back
    f_rd = 1'b1;
    step();
    f_rd = 1'b0;
    check("fwft unf", 32'(f_unf), 1);
    f_wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      f_wd = 8'(i + 1);
      step();
    end
    f_wr = 1'b0;
    step();
    step();
    check("fwft3 level", 32'(f_level), 3);
    for (int i = 0; i < 3; i++) begin
      check("fwft3 head", 32'(f_rdata), 32'(i + 1));
      check("fwft3 valid", 32'(f_rvld), 1);
      f_rd = 1'b1;
      step();
      f_rd = 1'b0;
    end
    check("fwft3 empty", 32'(f_empty), 1);
    check("fwft3 level0", 32'(f_level), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
